mult_dispatcher: RTL

//  Upstream feeder for the sequential multiplier (start/busy/valid/result interface).
//  - Buffers operand pairs from a valid/ready producer in a small FIFO.
//  - Issues them one at a time to the multiplier and collects each product.
//  - Presents each product on a valid/ready output port, in order.
//  - Keeps exactly one multiplication outstanding.

---
 rtl/mult_pkg.sv | 15 +
 rtl/mult_op_fifo.sv | 67 ++++++
 rtl/mult_dispatcher.sv | 94 +++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and defaults for the multiplier dispatcher.
// Dispatcher FSM state encoding plus default operand width and FIFO depth.
package mult_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } disp_state_t;

endpackage

// File: rtl/mult_op_fifo.sv
// mult_op_fifo: register-file FIFO of {a,b} operand pairs.
// Ports: push/push_a/push_b/ready in, pop/head_a/head_b/empty out, level.
module mult_op_fifo
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_a,
  input  logic [WIDTH-1:0] push_b,
  output logic             ready,
  input  logic             pop,
  output logic [WIDTH-1:0] head_a,
  output logic [WIDTH-1:0] head_b,
  output logic             empty,
  output logic [LW-1:0]    level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_nxt;
  logic [PW-1:0]      rd_nxt;
  logic               do_push;
  logic               do_pop;
  logic               full_nxt;

  assign do_push = push && ready;
  assign do_pop  = pop && !empty;
  assign wr_nxt  = wr_ptr + PW'(do_push);
  assign rd_nxt  = rd_ptr + PW'(do_pop);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = LW'(wr_ptr - rd_ptr);

  // ready is a flop holding !full of the next state, so it is 0 in
  // reset and never combinationally follows a same-cycle pop.
  assign full_nxt = (wr_nxt[PW-1] != rd_nxt[PW-1]) &&
                    (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ready  <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      ready  <= !full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= {push_a, push_b};
    end
  end

  assign {head_a, head_b} = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mult_dispatcher.sv
// mult_dispatcher: feeds operand pairs to a start/busy/valid multiplier.
// Ports: in_* producer side, out_* product side, mul_* multiplier, level_o.
module mult_dispatcher
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_a_i,
  input  logic [WIDTH-1:0]           in_b_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [2*WIDTH-1:0]         out_result_o,
  output logic                       mul_start_o,
  output logic [WIDTH-1:0]           mul_a_o,
  output logic [WIDTH-1:0]           mul_b_o,
  input  logic                       mul_busy_i,
  input  logic                       mul_valid_i,
  input  logic [2*WIDTH-1:0]         mul_result_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  disp_state_t      state;
  logic             fifo_empty;
  logic             pop;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;

  assign pop = (state == IDLE) && !fifo_empty && !mul_busy_i;

  mult_op_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .push   (in_valid_i),
    .push_a (in_a_i),
    .push_b (in_b_i),
    .ready  (in_ready_o),
    .pop    (pop),
    .head_a (head_a),
    .head_b (head_b),
    .empty  (fifo_empty),
    .level  (level_o)
  );

  // mul_valid_i is only looked at in WAIT; a result still held high
  // from the previous op is cleared by the multiplier during ISSUE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      mul_start_o  <= 1'b0;
      mul_a_o      <= '0;
      mul_b_o      <= '0;
      out_valid_o  <= 1'b0;
      out_result_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            mul_a_o     <= head_a;
            mul_b_o     <= head_b;
            mul_start_o <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          mul_start_o <= 1'b0;
          state       <= WAIT;
        end
        WAIT: begin
          if (mul_valid_i) begin
            out_result_o <= mul_result_i;
            out_valid_o  <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
